mac_dot_sequencer: RTL and testbench

- Controller that sequences the 4-bit accumulate-MAC datapath (8-bit accumulator, active-high async clear, free-running accumulate every clock) to compute one dot product of length N per command.
- Accepts a command, clears the MAC, streams N operand pairs in over a valid/ready handshake and feeds zeros on idle cycles.
- Holds the 8-bit result and a sticky overflow flag until the consumer takes them.
- Sits between the operand source/consumer and the MAC instance.

---
 rtl/mac_dot_sequencer.sv | 148 ++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
// Sequences a 4-bit multiply / 8-bit accumulate MAC to compute one dot
// product of length N per command.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// CLEAR | one cycle with mac_clr high, MAC accumulator zeroed
// RUN   | accepting operand pairs; idle cycles feed zeros to the MAC
// DRAIN | last pair is being accumulated by the MAC
// DONE  | result held on res_data until res_ready
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cmd_valid/ready/len   command handshake, element count N (0 legal)
//   abort                 cancel current operation (ignored in IDLE)
//   op_valid/ready/a/b    operand pair stream
//   mac_a/b/cin/clr       registered drive to the MAC instance
//   mac_result/cout       MAC accumulator value and adder carry-out
//   res_valid/ready/data  result handshake
//   res_ovf               sticky: accumulator wrapped during this command
//   busy                  high outside IDLE
module mac_dot_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_a,
  input  logic [3:0]       op_b,
  output logic [3:0]       mac_a,
  output logic [3:0]       mac_b,
  output logic             mac_cin,
  output logic             mac_clr,
  input  logic [7:0]       mac_result,
  input  logic             mac_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_ovf,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] count;
  logic             inflight;
  logic             idle_q;   // cmd_ready; stays low until the first edge after reset
  logic             beat;

  assign beat      = op_valid & op_ready;
  assign cmd_ready = idle_q;
  // abort blocks the beat so an aborted cycle never consumes an operand
  assign op_ready  = (state == S_RUN) & ~abort;
  assign res_valid = (state == S_DONE);
  // operands are zero in DONE, so mac_result is stable while presented
  assign res_data  = (state == S_DONE) ? mac_result : 8'h00;
  assign busy      = (state != S_IDLE);
  assign mac_cin   = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      mac_a    <= 4'h0;
      mac_b    <= 4'h0;
      mac_clr  <= 1'b1;
      res_ovf  <= 1'b0;
      inflight <= 1'b0;
      idle_q   <= 1'b0;
    end else begin
      // carry out of the adder while a real beat is summed means a wrap
      if (inflight && mac_cout) res_ovf <= 1'b1;

      if (state == S_IDLE) begin
        idle_q   <= 1'b1;
        mac_clr  <= 1'b0;
        mac_a    <= 4'h0;
        mac_b    <= 4'h0;
        inflight <= 1'b0;
        if (cmd_valid && idle_q) begin
          count   <= cmd_len;
          res_ovf <= 1'b0;
          mac_clr <= 1'b1;
          idle_q  <= 1'b0;
          state   <= S_CLEAR;
        end
      end else if (abort) begin
        // single-cycle clear pulse lands in the IDLE cycle that follows
        mac_a    <= 4'h0;
        mac_b    <= 4'h0;
        inflight <= 1'b0;
        mac_clr  <= 1'b1;
        idle_q   <= 1'b1;
        state    <= S_IDLE;
      end else begin
        case (state)
          S_CLEAR: begin
            mac_clr <= 1'b0;
            state   <= (count == '0) ? S_DONE : S_RUN;
          end
          S_RUN: begin
            if (beat) begin
              mac_a    <= op_a;
              mac_b    <= op_b;
              inflight <= 1'b1;
              count    <= count - 1'b1;
              if (count == {{(LEN_W-1){1'b0}}, 1'b1}) state <= S_DRAIN;
            end else begin
              mac_a    <= 4'h0;
              mac_b    <= 4'h0;
              inflight <= 1'b0;
            end
          end
          S_DRAIN: begin
            mac_a    <= 4'h0;
            mac_b    <= 4'h0;
            inflight <= 1'b0;
            state    <= S_DONE;
          end
          S_DONE: begin
            if (res_ready) begin
              idle_q <= 1'b1;
              state  <= S_IDLE;
            end
          end
          default: begin
            idle_q <= 1'b1;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Testbench for mac_dot_sequencer with a behavioural 4x4 MAC attached.
module tb_mac_dot_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_len = 8'h00;
  logic       abort = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] op_a = 4'h0;
  logic [3:0] op_b = 4'h0;
  logic [3:0] mac_a, mac_b;
  logic       mac_cin, mac_clr;
  logic [7:0] mac_result;
  logic       mac_cout;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_ovf;
  logic       busy;

  always #5 clk = ~clk;

  mac_dot_sequencer #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .abort(abort),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_cin(mac_cin), .mac_clr(mac_clr),
    .mac_result(mac_result), .mac_cout(mac_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .busy(busy)
  );

  // behavioural MAC: async active-high clear, accumulates every clock
  logic [7:0] acc;
  logic [8:0] sum9;
  assign sum9       = {1'b0, acc} + {1'b0, {4'h0, mac_a} * {4'h0, mac_b}} + {8'h00, mac_cin};
  assign mac_result = acc;
  assign mac_cout   = sum9[8];
  always @(posedge clk or posedge mac_clr) begin
    if (mac_clr) acc <= 8'h00;
    else         acc <= sum9[7:0];
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: {ovf, data} pushed at command accept, popped on result handshake
  logic [8:0] sb_q[$];

  logic       prev_beat = 1'b0;
  logic [3:0] prev_a = 4'h0, prev_b = 4'h0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_beat = 1'b0;
    end else begin
      chk("mac_a", {28'h0, mac_a}, {28'h0, prev_beat ? prev_a : 4'h0});
      chk("mac_b", {28'h0, mac_b}, {28'h0, prev_beat ? prev_b : 4'h0});
      chk("mac_cin", {31'h0, mac_cin}, 32'h0);
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 32'h1, 32'h0);
        end else begin
          logic [8:0] e;
          e = sb_q.pop_front();
          chk("res_data", {24'h0, res_data}, {24'h0, e[7:0]});
          chk("res_ovf", {31'h0, res_ovf}, {31'h0, e[8]});
        end
      end
      prev_beat = op_valid && op_ready;
      prev_a    = op_a;
      prev_b    = op_b;
    end
  end

  typedef struct {
    int         len;
    logic [3:0] a[8];
    logic [3:0] b[8];
    int         gap[8];
    int         hold;
    logic [7:0] exp_data;
    logic       exp_ovf;
  } vec_t;

  vec_t vec[7];

  task automatic run_cmd(input int idx);
    vec_t v;
    int   n;
    v = vec[idx];
    res_ready = (v.hold == 0);
    cmd_valid = 1'b1;
    cmd_len   = 8'(v.len);
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("cmd_ready_timeout", 32'h1, 32'h0);
    tick();
    sb_q.push_back({v.exp_ovf, v.exp_data});
    cmd_valid = 1'b0;
    chk("clear_busy", {31'h0, busy}, 32'h1);
    chk("clear_mac_clr", {31'h0, mac_clr}, 32'h1);
    chk("clear_op_ready", {31'h0, op_ready}, 32'h0);
    for (int i = 0; i < v.len; i++) begin
      op_valid = 1'b0;
      for (int g = 0; g < v.gap[i]; g++) tick();
      op_valid = 1'b1;
      op_a = v.a[i];
      op_b = v.b[i];
      n = 0;
      while (!op_ready && n < 50) begin tick(); n++; end
      if (n >= 50) chk("op_ready_timeout", 32'h1, 32'h0);
      tick();
    end
    op_valid = 1'b0;
    op_a = 4'h0;
    op_b = 4'h0;
    // one cycle of DRAIN (or CLEAR for N=0) before the result shows
    chk("res_valid_early", {31'h0, res_valid}, 32'h0);
    tick();
    chk("res_valid_latency", {31'h0, res_valid}, 32'h1);
    for (int h = 0; h < v.hold; h++) begin
      chk("hold_res_valid", {31'h0, res_valid}, 32'h1);
      chk("hold_res_data", {24'h0, res_data}, {24'h0, v.exp_data});
      chk("hold_op_ready", {31'h0, op_ready}, 32'h0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("back_to_idle", {31'h0, busy}, 32'h0);
    chk("idle_res_data", {24'h0, res_data}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{len: 3, a: '{3,2,1,0,0,0,0,0}, b: '{5,7,1,0,0,0,0,0},
               gap: '{0,0,0,0,0,0,0,0}, hold: 0, exp_data: 8'h1E, exp_ovf: 1'b0};
    vec[1] = '{len: 2, a: '{15,15,0,0,0,0,0,0}, b: '{15,15,0,0,0,0,0,0},
               gap: '{0,0,0,0,0,0,0,0}, hold: 0, exp_data: 8'hC2, exp_ovf: 1'b1};
    vec[2] = '{len: 1, a: '{2,0,0,0,0,0,0,0}, b: '{3,0,0,0,0,0,0,0},
               gap: '{0,0,0,0,0,0,0,0}, hold: 0, exp_data: 8'h06, exp_ovf: 1'b0};
    vec[3] = '{len: 0, a: '{0,0,0,0,0,0,0,0}, b: '{0,0,0,0,0,0,0,0},
               gap: '{0,0,0,0,0,0,0,0}, hold: 5, exp_data: 8'h00, exp_ovf: 1'b0};
    vec[4] = '{len: 4, a: '{1,3,5,7,0,0,0,0}, b: '{2,4,6,8,0,0,0,0},
               gap: '{0,1,3,2,0,0,0,0}, hold: 0, exp_data: 8'h64, exp_ovf: 1'b0};
    vec[5] = '{len: 1, a: '{4,0,0,0,0,0,0,0}, b: '{4,0,0,0,0,0,0,0},
               gap: '{0,0,0,0,0,0,0,0}, hold: 2, exp_data: 8'h10, exp_ovf: 1'b0};
    vec[6] = '{len: 1, a: '{9,0,0,0,0,0,0,0}, b: '{9,0,0,0,0,0,0,0},
               gap: '{0,0,0,0,0,0,0,0}, hold: 0, exp_data: 8'h51, exp_ovf: 1'b0};

    // reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_mac_clr", {31'h0, mac_clr}, 32'h1);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rst_op_ready", {31'h0, op_ready}, 32'h0);
    chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
    chk("rst_res_ovf", {31'h0, res_ovf}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_mac_a", {28'h0, mac_a}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("idle_mac_clr", {31'h0, mac_clr}, 32'h0);

    for (int r = 0; r < 5; r++) run_cmd(r);

    // abort after two beats of an N=5 command, with a beat offered at the same time
    cmd_valid = 1'b1;
    cmd_len   = 8'd5;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1;
      op_a = 4'(i + 1);
      op_b = 4'(i + 2);
      for (int n = 0; n < 50 && !op_ready; n++) tick();
      tick();
    end
    op_a = 4'h6;
    op_b = 4'h6;
    abort = 1'b1;
    #1;
    chk("abort_op_ready", {31'h0, op_ready}, 32'h0);
    tick();
    abort = 1'b0;
    op_valid = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_mac_clr", {31'h0, mac_clr}, 32'h1);
    chk("abort_res_valid", {31'h0, res_valid}, 32'h0);
    tick();
    chk("abort_clr_pulse_end", {31'h0, mac_clr}, 32'h0);
    chk("abort_acc_cleared", {24'h0, mac_result}, 32'h0);
    run_cmd(5);

    // abort is ignored in IDLE
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_mac_clr", {31'h0, mac_clr}, 32'h0);

    // reset in the middle of RUN
    cmd_valid = 1'b1;
    cmd_len   = 8'd3;
    tick();
    cmd_valid = 1'b0;
    op_valid = 1'b1;
    op_a = 4'h7;
    op_b = 4'h7;
    for (int n = 0; n < 50 && !op_ready; n++) tick();
    tick();
    op_valid = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_mac_clr", {31'h0, mac_clr}, 32'h1);
    chk("midrst_mac_a", {28'h0, mac_a}, 32'h0);
    chk("midrst_op_ready", {31'h0, op_ready}, 32'h0);
    chk("midrst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("midrst_acc", {24'h0, mac_result}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_cmd(6);

    tick();
    chk("scoreboard_empty", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
